appr_div_radix4: RTL and testbench

APPR_DIV_RADIX4 -- requirements
Module: appr_div_radix4

---
 rtl/appr_pkg.sv | 15 +
 rtl/appr_div_radix4_if.sv | 24 ++
 rtl/appr_div_digit_sel.sv | 35 +++
 rtl/appr_div_radix4.sv | 123 ++++++++++++
 tb/tb_appr_div_radix4.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/appr_pkg.sv
// Shared types for the radix-4 restoring divider: FSM encoding and digit-counter sizing.
package appr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } appr_state_e;

  // Counter must be able to hold the value DW (number of radix-4 digits).
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/appr_div_radix4_if.sv
// Operand/result handshake bundle for appr_div_radix4; master drives operands, slave returns results.
interface appr_div_radix4_if #(
  parameter int DW = 8
);
  logic            valid;
  logic            ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            res_valid;
  logic            res_ready;
  logic [2*DW-1:0] quotient;
  logic [DW-1:0]   remainder;
  logic            div_zero;

  modport master (
    output valid, dividend, divisor, res_ready,
    input  ready, res_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  valid, dividend, divisor, res_ready,
    output ready, res_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/appr_div_digit_sel.sv
// Radix-4 digit selector: picks the largest q in 0..3 with q*D <= P and returns P - q*D.
module appr_div_digit_sel #(
  parameter int DW = 8
) (
  input  logic [DW+1:0] p_i,
  input  logic [DW-1:0] d_i,
  output logic [1:0]    q_o,
  output logic [DW+1:0] r_o
);

  logic [DW+1:0] d1;
  logic [DW+1:0] d2;
  logic [DW+1:0] d3;

  // 3*D < 4*2^DW, so every multiple fits the DW+2 bit partial width.
  assign d1 = {2'b00, d_i};
  assign d2 = {1'b0, d_i, 1'b0};
  assign d3 = d1 + d2;

  always_comb begin
    q_o = 2'd0;
    r_o = p_i;
    if (p_i >= d3) begin
      q_o = 2'd3;
      r_o = p_i - d3;
    end else if (p_i >= d2) begin
      q_o = 2'd2;
      r_o = p_i - d2;
    end else if (p_i >= d1) begin
      q_o = 2'd1;
      r_o = p_i - d1;
    end
  end

endmodule

// File: rtl/appr_div_radix4.sv
// Sequential radix-4 divider: 2*DW-bit dividend by DW-bit divisor, one quotient digit per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | ready for operands; result outputs hold last values
// ST_CALC | retire one radix-4 digit per cycle; zero divisor passes through
// ST_DONE | result presented with oValid until iReady
module appr_div_radix4
  import appr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            iClk,
  input  logic            iRstn,
  input  logic            iValid,
  output logic            oReady,
  input  logic [2*DW-1:0] iDividend,
  input  logic [DW-1:0]   iDivisor,
  output logic            oValid,
  input  logic            iReady,
  output logic [2*DW-1:0] oQuotient,
  output logic [DW-1:0]   oRemainder,
  output logic            oDivZero
);

  localparam int CW = cnt_width(DW);
  localparam int QW = 2 * DW;

  appr_state_e   state_q;
  logic [QW-1:0] dvd_q;
  logic [DW-1:0] dvs_q;
  logic [DW+1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic [QW-1:0] quo_q;
  logic [DW-1:0] rmd_q;
  logic          dz_q;
  logic          valid_q;
  logic          ready_q;

  logic [DW+1:0] p_d;
  logic [1:0]    sel_q;
  logic [DW+1:0] rem_d;
  logic [QW-1:0] dvd_d;

  // dvd_q doubles as the quotient register: dividend bits leave at the top
  // while selected digits enter at the bottom.
  assign p_d   = (rem_q << 2) | {{DW{1'b0}}, dvd_q[QW-1 -: 2]};
  assign dvd_d = {dvd_q[QW-3:0], sel_q};

  appr_div_digit_sel #(.DW(DW)) u_digit_sel (
    .p_i (p_d),
    .d_i (dvs_q),
    .q_o (sel_q),
    .r_o (rem_d)
  );

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iValid) begin
            dvd_q   <= iDividend;
            dvs_q   <= iDivisor;
            rem_q   <= '0;
            // A zero divisor retires no digits and goes straight to DONE next edge.
            cnt_q   <= (iDivisor == '0) ? '0 : CW'(DW);
            ready_q <= 1'b0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            if (dvs_q == '0) begin
              quo_q <= '1;
              rmd_q <= dvd_q[DW-1:0];
              dz_q  <= 1'b1;
            end else begin
              quo_q <= dvd_q;
              rmd_q <= DW'(rem_q);
              dz_q  <= 1'b0;
            end
          end else begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          if (iReady) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign oReady     = ready_q;
  assign oValid     = valid_q;
  assign oQuotient  = quo_q;
  assign oRemainder = rmd_q;
  assign oDivZero   = dz_q;

endmodule

// File: tb/tb_appr_div_radix4.sv
// Scoreboard bench for appr_div_radix4: directed vectors, backpressure, mid-run reset, random pairs.
module tb_appr_div_radix4;
  localparam int DW = 8;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  logic iClk  = 1'b0;
  logic iRstn = 1'b0;
  bit   rand_phase = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  appr_div_radix4_if #(.DW(DW)) bus();

  appr_div_radix4 #(.DW(DW)) dut (
    .iClk       (iClk),
    .iRstn      (iRstn),
    .iValid     (bus.valid),
    .oReady     (bus.ready),
    .iDividend  (bus.dividend),
    .iDivisor   (bus.divisor),
    .oValid     (bus.res_valid),
    .iReady     (bus.res_ready),
    .oQuotient  (bus.quotient),
    .oRemainder (bus.remainder),
    .oDivZero   (bus.div_zero)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completed result handshake is checked against the oldest expectation.
  always @(negedge iClk) begin
    if (iRstn && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(bus.quotient), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
      end
    end
  end

  always @(posedge iClk) begin
    if (rand_phase) begin
      #1 bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!bus.ready && n < 200) begin
      bus.valid    = 1'($urandom_range(0, 1));
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      @(posedge iClk); #1;
      n++;
    end
    bus.valid = 1'b0;
    ok = bus.ready;
    if (!ok) chk("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic present(input logic [15:0] a, input logic [7:0] b);
    bus.valid    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge iClk); #1;
    bus.valid    = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (bus.res_valid && n < 200) begin
      @(posedge iClk); #1;
      n++;
    end
    if (bus.res_valid) chk("drain_timeout", 32'(bus.res_valid), 32'd0);
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                      input logic [7:0] er, input logic edz, input int exp_lat);
    bit   ok;
    int   lat;
    exp_t e;
    wait_ready(ok);
    if (ok) begin
      e.q = eq; e.r = er; e.dz = edz;
      present(a, b);
      sb.push_back(e);
      lat = 0;
      do begin
        @(posedge iClk); #1;
        lat++;
      end while (!bus.res_valid && lat < 50);
      chk("latency", 32'(lat), 32'(exp_lat));
      wait_drain();
    end
  endtask

  initial begin
    bit   ok;
    bit   saw;
    int   n;
    exp_t e;
    logic [15:0] a;
    logic [7:0]  b;

    bus.valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.res_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
    @(negedge iClk) iRstn = 1'b1;
    @(posedge iClk); #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);

    send(16'h1234, 8'h56, 16'h0036, 8'h10, 1'b0, 9);
    send(16'h00FF, 8'h00, 16'hFFFF, 8'hFF, 1'b1, 1);
    send(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 9);
    send(16'h0005, 8'hFF, 16'h0000, 8'h05, 1'b0, 9);
    send(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 9);
    send(16'hFEFF, 8'hFF, 16'h00FF, 8'hFE, 1'b0, 9);
    send(16'h0000, 8'h07, 16'h0000, 8'h00, 1'b0, 9);

    // Backpressure with concurrent new operands that must be ignored.
    bus.res_ready = 1'b0;
    wait_ready(ok);
    e.q = 16'h0036; e.r = 8'h10; e.dz = 1'b0;
    present(16'h1234, 8'h56);
    sb.push_back(e);
    n = 0;
    while (!bus.res_valid && n < 50) begin @(posedge iClk); #1; n++; end
    chk("bp_valid", 32'(bus.res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.valid = 1'b1; bus.dividend = 16'hAAAA; bus.divisor = 8'h03;
      @(posedge iClk); #1;
      chk("bp_quotient", 32'(bus.quotient), 32'h0036);
      chk("bp_remainder", 32'(bus.remainder), 32'h10);
      chk("bp_ready", 32'(bus.ready), 32'd0);
      chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge iClk); #1;
    chk("bp_release_valid", 32'(bus.res_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.ready), 32'd1);

    // Reset mid-CALC abandons the division.
    wait_ready(ok);
    present(16'h1234, 8'h56);
    repeat (3) @(posedge iClk);
    #2 iRstn = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    #4 iRstn = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge iClk); #1;
      if (bus.res_valid) saw = 1'b1;
    end
    chk("midrst_no_result", 32'(saw), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    send(16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 9);

    // Random pairs against a reference model with random gaps and stalls.
    rand_phase = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      wait_ready(ok);
      if (!ok) break;
      repeat ($urandom_range(0, 2)) begin @(posedge iClk); #1; end
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      e.dz = (b == 8'h00);
      e.q  = e.dz ? 16'hFFFF : a / {8'h00, b};
      e.r  = e.dz ? a[7:0] : 8'(a % {8'h00, b});
      present(a, b);
      sb.push_back(e);
    end
    rand_phase = 1'b0;
    @(posedge iClk); #2;
    bus.res_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge iClk); #1; n++; end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
